// File: rtl/stack_ptr_bank.sv
// Multi-channel hardware stack engine: CHANNELS stacks of DEPTH words share one memory port.
// Define STACK_BOUNDS_CHECK_EN to reject push-when-full / pop-when-empty; otherwise counts wrap.
module stack_ptr_bank #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 2,
  parameter int DEPTH    = 256,
  parameter int ADDR_W   = 16,
  localparam int CW = $clog2(DEPTH) + 1,
  localparam int GW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      CLK,
  input  logic                      Reset,
  input  logic [CHANNELS-1:0]       RegReset,
  input  logic [CHANNELS-1:0]       CmdValid,
  input  logic [CHANNELS-1:0]       CmdPop,
  input  logic [CHANNELS*WIDTH-1:0] CmdData,
  output logic [CHANNELS-1:0]       CmdReady,
  output logic [CHANNELS-1:0]       RspValid,
  output logic                      RspErr,
  output logic [WIDTH-1:0]          RspData,
  output logic                      MemReq,
  output logic                      MemWrite,
  output logic [ADDR_W-1:0]         MemAddr,
  output logic [WIDTH-1:0]          MemWData,
  input  logic                      MemAck,
  input  logic [WIDTH-1:0]          MemRData,
  output logic [CHANNELS*CW-1:0]    SPOut,
  output logic [CHANNELS-1:0]       Overflow,
  output logic [CHANNELS-1:0]       Underflow
);

  typedef enum logic [1:0] {IDLE, MEM, RESP} state_t;

  state_t                       state, nstate;
  logic [CHANNELS-1:0][CW-1:0]  count;
  logic [GW-1:0]                grant, last_grant, base, pick;
  logic                         op_pop, drop, any_req, legal, accept, decide;
  logic [ADDR_W-1:0]            addr;
  logic [WIDTH-1:0]             wdata;
  logic [CW-1:0]                cur_cnt, next_cnt, off_full;

  // CmdReady high in IDLE marks the accept cycle; a grant is decided one edge earlier
  // (from IDLE or straight out of RESP) so CmdReady can come from a flop.
  assign accept = (state == IDLE) && (|CmdReady);
  assign decide = ((state == IDLE) && !(|CmdReady)) || (state == RESP);
  assign SPOut  = count;

  always_comb begin
    any_req = 1'b0;
    pick    = '0;
    base    = (state == RESP) ? grant : last_grant;
    // Descending scan so the channel closest after base is the last (winning) assignment.
    for (int i = CHANNELS; i >= 1; i--) begin
      if (CmdValid[(int'(base) + i) % CHANNELS]) begin
        any_req = 1'b1;
        pick    = GW'((int'(base) + i) % CHANNELS);
      end
    end
  end

  always_comb begin
    cur_cnt = count[grant];
    if (op_pop) begin
      off_full = cur_cnt - CW'(1);
      next_cnt = (cur_cnt == '0) ? CW'(DEPTH) : cur_cnt - CW'(1);
    end else begin
      off_full = cur_cnt;
      next_cnt = (cur_cnt == CW'(DEPTH)) ? '0 : cur_cnt + CW'(1);
    end
`ifdef STACK_BOUNDS_CHECK_EN
    legal = op_pop ? (cur_cnt != '0) : (cur_cnt != CW'(DEPTH));
`else
    legal = 1'b1;
`endif
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (accept) nstate = legal ? MEM : RESP;
      MEM:     if (MemAck) nstate = RESP;
      RESP:    nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_comb begin
    MemReq   = (state == MEM);
    MemWrite = (state == MEM) && !op_pop;
    MemAddr  = addr;
    MemWData = wdata;
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      CmdReady   <= '0;
      RspValid   <= '0;
      RspErr     <= 1'b0;
      RspData    <= '0;
      grant      <= '0;
      last_grant <= GW'(CHANNELS - 1);
      op_pop     <= 1'b0;
      drop       <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
    end else begin
      CmdReady <= '0;
      RspValid <= '0;
      RspErr   <= 1'b0;
      if (decide && any_req) begin
        CmdReady <= CHANNELS'(1) << pick;
        grant    <= pick;
        op_pop   <= CmdPop[pick];
        wdata    <= CmdPop[pick] ? '0 : CmdData[int'(pick)*WIDTH +: WIDTH];
      end
      if (accept) begin
        addr <= ADDR_W'(int'(grant) * DEPTH) + ADDR_W'(off_full & CW'(DEPTH - 1));
        drop <= RegReset[grant];
        if (!legal) begin
          RspValid <= CHANNELS'(1) << grant;
          RspErr   <= 1'b1;
          RspData  <= '0;
        end
      end
      // A channel clear during the memory wait cancels this operation's count update.
      if (state == MEM && RegReset[grant]) drop <= 1'b1;
      if (state == MEM && MemAck) begin
        RspValid <= CHANNELS'(1) << grant;
        RspData  <= op_pop ? MemRData : '0;
      end
      if (state == RESP) begin
        last_grant <= grant;
        RspData    <= '0;
      end
    end
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) count <= '0;
    else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (RegReset[c])
          count[c] <= '0;
        else if (state == MEM && MemAck && !drop && int'(grant) == c)
          count[c] <= next_cnt;
      end
    end
  end

`ifdef STACK_BOUNDS_CHECK_EN
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      Overflow  <= '0;
      Underflow <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (RegReset[c]) begin
          Overflow[c]  <= 1'b0;
          Underflow[c] <= 1'b0;
        end else if (accept && !legal && int'(grant) == c) begin
          if (op_pop) Underflow[c] <= 1'b1;
          else        Overflow[c]  <= 1'b1;
        end
      end
    end
  end
`else
  assign Overflow  = '0;
  assign Underflow = '0;
`endif

endmodule

// File: tb/tb_stack_ptr_bank.sv
// Directed bench for stack_ptr_bank (defaults: 16-bit words, 2 channels, DEPTH 256).
// Uses a behavioural memory with programmable ack delay and a request-stability monitor.
module tb_stack_ptr_bank;
  localparam int WIDTH = 16, CHANNELS = 2, DEPTH = 256, ADDR_W = 16, CW = 9;

  logic                      CLK, Reset;
  logic [CHANNELS-1:0]       RegReset, CmdValid, CmdPop, CmdReady, RspValid;
  logic [CHANNELS*WIDTH-1:0] CmdData;
  logic                      RspErr, MemReq, MemWrite, MemAck;
  logic [WIDTH-1:0]          RspData, MemWData, MemRData;
  logic [ADDR_W-1:0]         MemAddr;
  logic [CHANNELS*CW-1:0]    SPOut;
  logic [CHANNELS-1:0]       Overflow, Underflow;

  stack_ptr_bank #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .Reset(Reset), .RegReset(RegReset), .CmdValid(CmdValid), .CmdPop(CmdPop),
    .CmdData(CmdData), .CmdReady(CmdReady), .RspValid(RspValid), .RspErr(RspErr),
    .RspData(RspData), .MemReq(MemReq), .MemWrite(MemWrite), .MemAddr(MemAddr),
    .MemWData(MemWData), .MemAck(MemAck), .MemRData(MemRData), .SPOut(SPOut),
    .Overflow(Overflow), .Underflow(Underflow));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int tests = 0, fails = 0, cyc = 0, ack_delay = 0;
  int mon_starts = 0, mon_cycles = 0, mon_unstable = 0;
  logic [15:0] mon_addr = '0, mon_wdata = '0;
  logic        mon_write = 1'b0;
  logic [15:0] mem [0:65535];

  initial forever @(posedge CLK) cyc++;

  // Memory model: acks after ack_delay wait cycles; records the first beat of each request.
  initial begin
    int  wcnt;
    logic prev;
    for (int a = 0; a < 65536; a++) mem[a] = 16'(a) ^ 16'hC3C3;
    MemAck = 1'b0; MemRData = '0; wcnt = 0; prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (MemReq) begin
        if (!prev) begin
          mon_starts++; mon_addr = MemAddr; mon_write = MemWrite; mon_wdata = MemWData;
        end else if (MemAddr !== mon_addr || MemWrite !== mon_write || MemWData !== mon_wdata)
          mon_unstable++;
        mon_cycles++;
        if (wcnt == ack_delay) begin
          MemAck = 1'b1; MemRData = mem[MemAddr];
          if (MemWrite) mem[MemAddr] = MemWData;
          wcnt = 0;
        end else begin
          MemAck = 1'b0; MemRData = '0; wcnt++;
        end
      end else begin
        MemAck = 1'b0; MemRData = '0; wcnt = 0;
      end
      prev = MemReq;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_cmd(input int ch, input logic pop, input logic [15:0] data,
                        output int lat, output logic [15:0] rdata, output logic err,
                        output logic ok);
    int c0, n;
    @(negedge CLK);
    CmdValid[ch] = 1'b1; CmdPop[ch] = pop; CmdData[ch*WIDTH +: WIDTH] = data;
    n = 0;
    while (!CmdReady[ch] && n < 50) begin @(negedge CLK); n++; end
    ok = CmdReady[ch]; c0 = cyc; CmdValid[ch] = 1'b0;
    n = 0;
    @(negedge CLK);
    while (!RspValid[ch] && n < 50) begin @(negedge CLK); n++; end
    ok = ok & RspValid[ch]; lat = cyc - c0; rdata = RspData; err = RspErr;
  endtask

  typedef struct {
    int ch; logic pop; logic [15:0] data; int dly;
    logic [15:0] addr; logic [15:0] rdata; int lat; logic [8:0] sp;
  } vec_t;
  vec_t vecs[8];

  initial begin
    int lat, s0, u0, k0, n, c0, errs;
    logic [15:0] rd;
    logic er, ok;

    vecs[0] = '{0, 1'b0, 16'h1234, 0, 16'h0000, 16'h0000, 2, 9'd1};
    vecs[1] = '{0, 1'b1, 16'h0000, 0, 16'h0000, 16'h1234, 2, 9'd0};
    vecs[2] = '{1, 1'b0, 16'hBEEF, 0, 16'h0100, 16'h0000, 2, 9'd1};
    vecs[3] = '{1, 1'b0, 16'h0F0F, 3, 16'h0101, 16'h0000, 5, 9'd2};
    vecs[4] = '{1, 1'b1, 16'h0000, 1, 16'h0101, 16'h0F0F, 3, 9'd1};
    vecs[5] = '{0, 1'b0, 16'hA5A5, 2, 16'h0000, 16'h0000, 4, 9'd1};
    vecs[6] = '{1, 1'b1, 16'h0000, 0, 16'h0100, 16'hBEEF, 2, 9'd0};
    vecs[7] = '{0, 1'b1, 16'h0000, 0, 16'h0000, 16'hA5A5, 2, 9'd0};

    Reset = 1'b1; RegReset = '0; CmdValid = '0; CmdPop = '0; CmdData = '0;
    repeat (3) @(negedge CLK);
    chk("rst SPOut", 32'(SPOut), 0);
    chk("rst CmdReady/RspValid", {CmdReady, RspValid}, 0);
    chk("rst RspErr/RspData", {RspErr, RspData}, 0);
    chk("rst MemReq/MemWrite", {MemReq, MemWrite}, 0);
    chk("rst MemAddr/MemWData", {MemAddr, MemWData}, 0);
    chk("rst flags", {Overflow, Underflow}, 0);
    Reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      ack_delay = vecs[i].dly; s0 = mon_starts; u0 = mon_unstable; k0 = mon_cycles;
      do_cmd(vecs[i].ch, vecs[i].pop, vecs[i].data, lat, rd, er, ok);
      chk($sformatf("v%0d handshake", i), 32'(ok), 1);
      chk($sformatf("v%0d mem starts", i), mon_starts - s0, 1);
      chk($sformatf("v%0d MemAddr", i), mon_addr, vecs[i].addr);
      chk($sformatf("v%0d MemWrite", i), mon_write, !vecs[i].pop);
      chk($sformatf("v%0d MemWData", i), mon_wdata, vecs[i].pop ? 16'h0 : vecs[i].data);
      chk($sformatf("v%0d req cycles", i), mon_cycles - k0, vecs[i].dly + 1);
      chk($sformatf("v%0d req unstable", i), mon_unstable - u0, 0);
      chk($sformatf("v%0d RspData", i), rd, vecs[i].rdata);
      chk($sformatf("v%0d RspErr", i), er, 0);
      chk($sformatf("v%0d latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d SPOut", i), SPOut[vecs[i].ch*CW +: CW], vecs[i].sp);
    end

    // Reset re-arms round-robin so ch0 wins even though ch0 was served last.
    @(negedge CLK); Reset = 1'b1; @(negedge CLK); Reset = 1'b0;
    ack_delay = 0;
    @(negedge CLK);
    CmdValid = 2'b11; CmdPop = 2'b00; CmdData = {16'h2222, 16'h1111};
    n = 0;
    while (CmdReady == '0 && n < 50) begin @(negedge CLK); n++; end
    chk("sim first grant", CmdReady, 2'b01);
    c0 = cyc; CmdValid[0] = 1'b0;
    n = 0;
    @(negedge CLK);
    while (!CmdReady[1] && n < 50) begin @(negedge CLK); n++; end
    chk("sim grant gap", cyc - c0, 3);
    CmdValid[1] = 1'b0;
    n = 0;
    @(negedge CLK);
    while (!RspValid[1] && n < 50) begin @(negedge CLK); n++; end
    chk("sim ch1 rsp", RspValid[1], 1);
    chk("sim ch1 MemAddr", mon_addr, 16'h0100);
    chk("sim ch1 MemWData", mon_wdata, 16'h2222);
    chk("sim SPOut", 32'(SPOut), {14'd0, 9'd1, 9'd1});

    do_cmd(0, 1'b1, 16'h0, lat, rd, er, ok);
    chk("pop ch0 data", rd, 16'h1111);
    chk("pop ch0 SPOut", SPOut[0 +: CW], 0);

`ifdef STACK_BOUNDS_CHECK_EN
    s0 = mon_starts;
    do_cmd(0, 1'b1, 16'h0, lat, rd, er, ok);
    chk("underflow RspErr", er, 1);
    chk("underflow latency", lat, 1);
    chk("underflow no mem", mon_starts - s0, 0);
    chk("underflow flag", Underflow, 2'b01);
    chk("underflow SPOut", SPOut[0 +: CW], 0);
    @(negedge CLK); RegReset = 2'b11; @(negedge CLK); RegReset = '0;
    chk("regreset clears flag", Underflow, 0);
    errs = 0;
    for (int i = 0; i < DEPTH; i++) begin
      do_cmd(1, 1'b0, 16'(i), lat, rd, er, ok);
      if (er || !ok) errs++;
    end
    chk("fill errs", errs, 0);
    chk("fill SPOut", SPOut[CW +: CW], 9'd256);
    s0 = mon_starts;
    do_cmd(1, 1'b0, 16'hDEAD, lat, rd, er, ok);
    chk("overflow RspErr", er, 1);
    chk("overflow no mem", mon_starts - s0, 0);
    chk("overflow flag", Overflow, 2'b10);
    chk("overflow SPOut", SPOut[CW +: CW], 9'd256);
`else
    do_cmd(0, 1'b1, 16'h0, lat, rd, er, ok);
    chk("wrap pop RspErr", er, 0);
    chk("wrap pop MemAddr", mon_addr, 16'h00FF);
    chk("wrap pop data", rd, 16'hC33C);
    chk("wrap pop SPOut", SPOut[0 +: CW], 9'd256);
    do_cmd(0, 1'b0, 16'h7777, lat, rd, er, ok);
    chk("wrap push MemAddr", mon_addr, 16'h0000);
    chk("wrap push SPOut", SPOut[0 +: CW], 0);
    chk("wrap flags", {Overflow, Underflow}, 0);
`endif

    // Channel clear during a delayed write: response still arrives, count stays cleared.
    ack_delay = 0;
    do_cmd(0, 1'b0, 16'h4444, lat, rd, er, ok);
    chk("pre-clear SPOut", SPOut[0 +: CW], 1);
    ack_delay = 3;
    fork
      do_cmd(0, 1'b0, 16'h5555, lat, rd, er, ok);
      begin
        repeat (5) @(negedge CLK);
        RegReset[0] = 1'b1;
        @(negedge CLK);
        RegReset[0] = 1'b0;
      end
    join
    chk("clear rsp delivered", ok, 1);
    chk("clear latency", lat, 5);
    chk("clear SPOut", SPOut[0 +: CW], 0);

    // Async reset mid-MEM: MemReq drops at once, no response follows.
    ack_delay = 10;
    @(negedge CLK);
    CmdValid[1] = 1'b1; CmdPop[1] = 1'b0; CmdData[WIDTH +: WIDTH] = 16'h6666;
    n = 0;
    while (!CmdReady[1] && n < 50) begin @(negedge CLK); n++; end
    CmdValid[1] = 1'b0;
    @(negedge CLK);
    chk("abort MemReq before", MemReq, 1);
    #2 Reset = 1'b1;
    #1 chk("abort MemReq async", MemReq, 0);
    n = 0;
    @(negedge CLK); @(negedge CLK); Reset = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge CLK);
      if (RspValid != '0 || MemReq) n++;
    end
    chk("abort no rsp", n, 0);
    chk("abort SPOut", 32'(SPOut), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
